int_datapath_md: RTL and testbench

- Parametrised next-generation integer datapath: register file, registered operand stage, single-cycle ALU, and an iterative multiply/divide engine feeding HI/LO.
- Adds a start/busy/done handshake, signed and unsigned multiply and divide, and divide-by-zero reporting.
- Sits between the MCU (control, flags) and the memory interface (d_out, alu_out).

---
 rtl/int_dp_pkg.sv | 50 +++++
 rtl/int_datapath_md_if.sv | 55 +++++
 rtl/muldiv_iter.sv | 137 +++++++++++++
 rtl/regfile_param.sv | 33 +++
 rtl/int_datapath_md.sv | 155 +++++++++++++++
 tb/tb_int_datapath_md.sv | 361 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/int_dp_pkg.sv
// Shared encodings for the integer datapath:
// ALU functions, mul/div ops, mux selects, FSM states.
package int_dp_pkg;

  typedef enum logic [3:0] {
    FS_PASS_S = 4'h0,
    FS_PASS_T = 4'h1,
    FS_ADD    = 4'h2,
    FS_ADDU   = 4'h3,
    FS_SUB    = 4'h4,
    FS_SUBU   = 4'h5,
    FS_SLT    = 4'h6,
    FS_SLTU   = 4'h7,
    FS_AND    = 4'h8,
    FS_OR     = 4'h9,
    FS_XOR    = 4'hA,
    FS_NOR    = 4'hB,
    FS_SLL    = 4'hC,
    FS_SRL    = 4'hD,
    FS_SRA    = 4'hE,
    FS_INC    = 4'hF
  } fs_e;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    DA_D  = 2'b00,
    DA_T  = 2'b01,
    DA_LR = 2'b10,
    DA_SP = 2'b11
  } da_sel_e;

  localparam logic [2:0] Y_ALU = 3'b000;
  localparam logic [2:0] Y_HI  = 3'b001;
  localparam logic [2:0] Y_LO  = 3'b010;
  localparam logic [2:0] Y_DIN = 3'b011;
  localparam logic [2:0] Y_PC  = 3'b100;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/int_datapath_md_if.sv
// Control/data bundle between the MCU side
// and the integer datapath.
interface int_datapath_md_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  localparam int SW = $clog2(DATA_W);

  logic [AW-1:0]     s_addr;
  logic [AW-1:0]     t_addr;
  logic [AW-1:0]     d_addr;
  logic              d_en;
  logic [1:0]        da_sel;
  logic              t_sel;
  logic [DATA_W-1:0] dt;
  logic              s_sel;
  logic [3:0]        fs;
  logic [SW-1:0]     shamt;
  logic [2:0]        y_sel;
  logic [DATA_W-1:0] dy;
  logic [DATA_W-1:0] pc_in;
  logic              md_start;
  logic [1:0]        md_op;
  logic              md_busy;
  logic              md_done;
  logic              div_zero;
  logic              c;
  logic              v;
  logic              n;
  logic              z;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] d_out;
  logic [DATA_W-1:0] d_in;

  modport master (
    output s_addr, t_addr, d_addr, d_en,
    output da_sel, t_sel, dt, s_sel,
    output fs, shamt, y_sel, dy, pc_in,
    output md_start, md_op,
    input  md_busy, md_done, div_zero,
    input  c, v, n, z,
    input  alu_out, d_out, d_in
  );

  modport slave (
    input  s_addr, t_addr, d_addr, d_en,
    input  da_sel, t_sel, dt, s_sel,
    input  fs, shamt, y_sel, dy, pc_in,
    input  md_start, md_op,
    output md_busy, md_done, div_zero,
    output c, v, n, z,
    output alu_out, d_out, d_in
  );

endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply/divide on operand
// magnitudes, sign fix-up in DONE, result in HI/LO.
module muldiv_iter
  import int_dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(DATA_W);
  localparam int M  = DATA_W - 1;

  md_state_e         state;
  logic [CW-1:0]     cnt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  assign a_mag = (op[0] && a[M]) ? -a : a;
  assign b_mag = (op[0] && b[M]) ? -b : b;

  logic [DATA_W:0]   m_sum;
  logic [DATA_W:0]   r_sh;
  logic              ge;
  logic [DATA_W-1:0] n_hi;
  logic [DATA_W-1:0] n_lo;

  // mul: acc_hi:acc_lo shifts right; div: remainder builds in acc_hi
  always_comb begin
    m_sum = {1'b0, acc_hi} +
            (acc_lo[0] ? {1'b0, opb} : '0);
    r_sh  = {acc_hi, acc_lo[M]};
    ge    = r_sh >= {1'b0, opb};
    if (op_q[1]) begin
      n_hi = ge ? DATA_W'(r_sh - {1'b0, opb})
                : r_sh[M:0];
      n_lo = {acc_lo[M-1:0], ge};
    end else begin
      n_hi = m_sum[DATA_W:1];
      n_lo = {m_sum[0], acc_lo[M:1]};
    end
  end

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_f;
  logic [DATA_W-1:0]   q_f;
  logic [DATA_W-1:0]   r_f;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;
  logic                neg_ab;
  logic                bz;

  always_comb begin
    neg_ab = op_q[0] & (a_q[M] ^ b_q[M]);
    bz     = (b_q == '0);
    prod   = {acc_hi, acc_lo};
    prod_f = neg_ab ? -prod : prod;
    q_f    = neg_ab ? -acc_lo : acc_lo;
    r_f    = (op_q[0] && a_q[M]) ? -acc_hi : acc_hi;
    res_hi = prod_f[2*DATA_W-1:DATA_W];
    res_lo = prod_f[M:0];
    if (op_q[1]) begin
      res_hi = bz ? a_q : r_f;
      res_lo = bz ? '1 : q_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opb      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            opb      <= b_mag;
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            cnt      <= CW'(DATA_W - 1);
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc_hi <= n_hi;
          acc_lo <= n_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == '0)
            state <= MD_DONE;
        end
        MD_DONE: begin
          hi       <= res_hi;
          lo       <= res_lo;
          div_zero <= op_q[1] & bz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_param.sv
// REG_CNT x DATA_W register file, two async
// read ports, one sync write port, r0 hardwired 0.
module regfile_param #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int AW      = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra_s,
  input  logic [AW-1:0]     ra_t,
  output logic [DATA_W-1:0] rd_s,
  output logic [DATA_W-1:0] rd_t
);

  logic [DATA_W-1:0] mem [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++)
        mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd_s = (ra_s == '0) ? '0 : mem[ra_s];
  assign rd_t = (ra_t == '0) ? '0 : mem[ra_t];

endmodule

// File: rtl/int_datapath_md.sv
// Integer datapath: regfile, RS/RT operand regs,
// single-cycle ALU, iterative mul/div into HI/LO.
module int_datapath_md
  import int_dp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input logic clk,
  input logic reset,
  int_datapath_md_if.slave bus
);

  localparam int AW     = $clog2(REG_CNT);
  localparam int M      = DATA_W - 1;
  localparam int SP_IDX = REG_CNT - 3;
  localparam int LR_IDX = REG_CNT - 1;

  logic [DATA_W-1:0] s_val;
  logic [DATA_W-1:0] t_val;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic [DATA_W-1:0] alu_reg;
  logic [DATA_W-1:0] d_in_q;
  logic [DATA_W-1:0] y_lo;
  logic [DATA_W-1:0] y_out;
  logic [DATA_W-1:0] d_out_w;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [AW-1:0]     wa;

  always_comb begin
    wa = bus.d_addr;
    case (bus.da_sel)
      DA_D:    wa = bus.d_addr;
      DA_T:    wa = bus.t_addr;
      DA_LR:   wa = AW'(LR_IDX);
      default: wa = AW'(SP_IDX);
    endcase
  end

  regfile_param #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_rf (
    .clk   (clk),
    .rst_n (reset),
    .we    (bus.d_en),
    .wa    (wa),
    .wd    (y_out),
    .ra_s  (bus.s_addr),
    .ra_t  (bus.t_addr),
    .rd_s  (s_val),
    .rd_t  (t_val)
  );

  assign d_out_w = bus.t_sel ? bus.dt : t_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs      <= '0;
      rt      <= '0;
      alu_reg <= '0;
      d_in_q  <= '0;
    end else begin
      rt      <= d_out_w;
      rs      <= bus.s_sel ? y_lo : s_val;
      alu_reg <= y_lo;
      d_in_q  <= bus.dy;
    end
  end

  logic [DATA_W:0] sum;
  logic            cf;
  logic            vf;

  // SUB carry is the adder carry of rs + ~rt + 1, i.e. no-borrow
  always_comb begin
    sum  = '0;
    y_lo = '0;
    cf   = 1'b0;
    vf   = 1'b0;
    unique case (bus.fs)
      FS_PASS_S: y_lo = rs;
      FS_PASS_T: y_lo = rt;
      FS_ADD, FS_ADDU: begin
        sum  = {1'b0, rs} + {1'b0, rt};
        y_lo = sum[M:0];
        cf   = sum[DATA_W];
        vf   = (bus.fs == FS_ADD) &&
               (rs[M] == rt[M]) && (y_lo[M] != rs[M]);
      end
      FS_SUB, FS_SUBU: begin
        sum  = {1'b0, rs} + {1'b0, ~rt} +
               (DATA_W+1)'(1);
        y_lo = sum[M:0];
        cf   = sum[DATA_W];
        vf   = (bus.fs == FS_SUB) &&
               (rs[M] != rt[M]) && (y_lo[M] != rs[M]);
      end
      FS_SLT:  y_lo = DATA_W'($signed(rs) < $signed(rt));
      FS_SLTU: y_lo = DATA_W'(rs < rt);
      FS_AND:  y_lo = rs & rt;
      FS_OR:   y_lo = rs | rt;
      FS_XOR:  y_lo = rs ^ rt;
      FS_NOR:  y_lo = ~(rs | rt);
      FS_SLL:  y_lo = rt << bus.shamt;
      FS_SRL:  y_lo = rt >> bus.shamt;
      FS_SRA:  y_lo = $signed(rt) >>> bus.shamt;
      FS_INC: begin
        sum  = {1'b0, rs} + (DATA_W+1)'(1);
        y_lo = sum[M:0];
        cf   = sum[DATA_W];
        vf   = ~rs[M] & y_lo[M];
      end
    endcase
  end

  always_comb begin
    y_out = '0;
    case (bus.y_sel)
      Y_ALU:   y_out = alu_reg;
      Y_HI:    y_out = hi;
      Y_LO:    y_out = lo;
      Y_DIN:   y_out = d_in_q;
      Y_PC:    y_out = bus.pc_in;
      default: y_out = '0;
    endcase
  end

  muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_md (
    .clk      (clk),
    .rst_n    (reset),
    .start    (bus.md_start),
    .op       (bus.md_op),
    .a        (rs),
    .b        (rt),
    .busy     (bus.md_busy),
    .done     (bus.md_done),
    .div_zero (bus.div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  assign bus.c       = cf;
  assign bus.v       = vf;
  assign bus.n       = y_lo[M];
  assign bus.z       = (y_lo == '0);
  assign bus.alu_out = y_out;
  assign bus.d_out   = d_out_w;
  assign bus.d_in    = d_in_q;

endmodule

// File: tb/tb_int_datapath_md.sv
// Bench for int_datapath_md: 32-bit and 16-bit
// builds against an arithmetic reference model.
module tb_int_datapath_md;
  import int_dp_pkg::*;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  int_datapath_md_if #(.DATA_W(32), .AW(5)) b32 ();
  int_datapath_md_if #(.DATA_W(16), .AW(4)) b16 ();

  int_datapath_md #(.DATA_W(32), .REG_CNT(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  int_datapath_md #(.DATA_W(16), .REG_CNT(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {c,v,n,z,y} from plain integer arithmetic
  function automatic logic [35:0] alu_ref(
    logic [3:0] f, logic [31:0] a,
    logic [31:0] b, logic [4:0] sh);
    longint sa, sb, sr;
    logic [32:0] w;
    logic [31:0] y;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    y = '0; c = 1'b0; v = 1'b0;
    case (f)
      4'h0: y = a;
      4'h1: y = b;
      4'h2, 4'h3: begin
        w = {1'b0, a} + {1'b0, b};
        y = w[31:0]; c = w[32];
        sr = sa + sb;
        v = (f == 4'h2) && (sr > MAXI || sr < MINI);
      end
      4'h4, 4'h5: begin
        y = a - b; c = (a >= b);
        sr = sa - sb;
        v = (f == 4'h4) && (sr > MAXI || sr < MINI);
      end
      4'h6: y = {31'b0, sa < sb};
      4'h7: y = {31'b0, a < b};
      4'h8: y = a & b;
      4'h9: y = a | b;
      4'hA: y = a ^ b;
      4'hB: y = ~(a | b);
      4'hC: y = b << sh;
      4'hD: y = b >> sh;
      4'hE: y = 32'(sb >>> sh);
      default: begin
        w = {1'b0, a} + 33'd1;
        y = w[31:0]; c = w[32];
        sr = sa + 1;
        v = sr > MAXI;
      end
    endcase
    return {c, v, y[31], y == 32'h0, y};
  endfunction

  // {div_zero, hi, lo} for width w (16 or 32)
  function automatic logic [64:0] md_model(
    int w, logic [1:0] op,
    logic [31:0] a, logic [31:0] b);
    logic [63:0] msk, ua, ub, p, hi, lo;
    longint sa, sb;
    logic dz;
    msk = (64'd1 << w) - 64'd1;
    ua = {32'b0, a} & msk;
    ub = {32'b0, b} & msk;
    sa = a[w-1] ? longint'(ua) - longint'(64'd1 << w)
                : longint'(ua);
    sb = b[w-1] ? longint'(ub) - longint'(64'd1 << w)
                : longint'(ub);
    dz = 1'b0; p = '0; hi = '0; lo = '0;
    case (op)
      2'b00: p = ua * ub;
      2'b01: p = 64'(sa * sb);
      default: ;
    endcase
    hi = (p >> w) & msk;
    lo = p & msk;
    if (op[1]) begin
      if (ub == 0) begin
        dz = 1'b1; lo = msk; hi = ua;
      end else if (op == 2'b10) begin
        lo = ua / ub; hi = ua % ub;
      end else begin
        lo = 64'(sa / sb) & msk;
        hi = 64'(sa % sb) & msk;
      end
    end
    return {dz, hi[31:0], lo[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // RT <= a, then RS <= a (forwarded), RT <= b
  task automatic load32(logic [31:0] a, logic [31:0] bb);
    b32.t_sel = 1'b1; b32.dt = a; b32.s_sel = 1'b0;
    step();
    b32.fs = FS_PASS_T; b32.s_sel = 1'b1; b32.dt = bb;
    step();
    b32.s_sel = 1'b0; b32.t_sel = 1'b0;
  endtask

  task automatic alu_check(string tag, logic [3:0] f,
    logic [31:0] a, logic [31:0] bb, logic [4:0] sh,
    output logic [35:0] got);
    logic [35:0] r;
    load32(a, bb);
    r = alu_ref(f, a, bb, sh);
    b32.fs = f; b32.shamt = sh; b32.y_sel = Y_ALU;
    #1;
    got[35:32] = {b32.c, b32.v, b32.n, b32.z};
    chk($sformatf("%s_flags", tag), 64'(got[35:32]),
        64'(r[35:32]));
    step();
    got[31:0] = b32.alu_out;
    chk($sformatf("%s_y", tag), 64'(got[31:0]),
        64'(r[31:0]));
  endtask

  task automatic md_run(string tag, logic [1:0] op,
    logic [31:0] a, logic [31:0] bb, int pulse_at);
    logic [64:0] r;
    int dc;
    load32(a, bb);
    r = md_model(32, op, a, bb);
    b32.md_op = op; b32.md_start = 1'b1;
    step();
    b32.md_start = 1'b0;
    chk($sformatf("%s_busy", tag), 64'(b32.md_busy), 64'd1);
    chk($sformatf("%s_dzclr", tag), 64'(b32.div_zero), 64'd0);
    dc = -1;
    for (int cy = 1; cy <= 40 && dc < 0; cy++) begin
      if (cy == pulse_at) begin
        b32.md_start = 1'b1; b32.md_op = ~op;
      end
      if (cy == 3) begin
        b32.y_sel = Y_HI; #1;
        chk($sformatf("%s_hihold", tag),
            64'(b32.alu_out), 64'(exp_hi));
        b32.y_sel = Y_LO; #1;
        chk($sformatf("%s_lohold", tag),
            64'(b32.alu_out), 64'(exp_lo));
      end
      step();
      b32.md_start = 1'b0; b32.md_op = op;
      if (b32.md_done) dc = cy;
    end
    chk($sformatf("%s_lat", tag), 64'(dc), 64'd33);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    b32.y_sel = Y_HI; #1;
    chk($sformatf("%s_hi", tag), 64'(b32.alu_out), 64'(exp_hi));
    b32.y_sel = Y_LO; #1;
    chk($sformatf("%s_lo", tag), 64'(b32.alu_out), 64'(exp_lo));
    chk($sformatf("%s_dz", tag), 64'(b32.div_zero), 64'(r[64]));
    chk($sformatf("%s_idle", tag), 64'(b32.md_busy), 64'd0);
    step();
    chk($sformatf("%s_pulse", tag), 64'(b32.md_done), 64'd0);
  endtask

  task automatic md16(string tag, logic [1:0] op,
    logic [15:0] a, logic [15:0] bb);
    logic [64:0] r;
    int dc;
    b16.t_sel = 1'b1; b16.dt = a; b16.s_sel = 1'b0;
    step();
    b16.fs = FS_PASS_T; b16.s_sel = 1'b1; b16.dt = bb;
    step();
    b16.s_sel = 1'b0; b16.t_sel = 1'b0;
    r = md_model(16, op, {16'b0, a}, {16'b0, bb});
    b16.md_op = op; b16.md_start = 1'b1;
    step();
    b16.md_start = 1'b0;
    dc = -1;
    for (int cy = 1; cy <= 30 && dc < 0; cy++) begin
      step();
      if (b16.md_done) dc = cy;
    end
    chk($sformatf("%s_lat", tag), 64'(dc), 64'd17);
    b16.y_sel = Y_HI; #1;
    chk($sformatf("%s_hi", tag), 64'(b16.alu_out),
        64'(r[47:32]));
    b16.y_sel = Y_LO; #1;
    chk($sformatf("%s_lo", tag), 64'(b16.alu_out),
        64'(r[15:0]));
    chk($sformatf("%s_dz", tag), 64'(b16.div_zero),
        64'(r[64]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] got;
    logic [3:0] f;
    logic [1:0] op;

    b32.s_addr = '0; b32.t_addr = '0; b32.d_addr = '0;
    b32.d_en = 1'b0; b32.da_sel = '0; b32.t_sel = 1'b0;
    b32.dt = '0; b32.s_sel = 1'b0; b32.fs = '0;
    b32.shamt = '0; b32.y_sel = '0; b32.dy = '0;
    b32.pc_in = '0; b32.md_start = 1'b0; b32.md_op = '0;
    b16.s_addr = '0; b16.t_addr = '0; b16.d_addr = '0;
    b16.d_en = 1'b0; b16.da_sel = '0; b16.t_sel = 1'b0;
    b16.dt = '0; b16.s_sel = 1'b0; b16.fs = '0;
    b16.shamt = '0; b16.y_sel = '0; b16.dy = '0;
    b16.pc_in = '0; b16.md_start = 1'b0; b16.md_op = '0;

    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();

    // reset state
    for (int ys = 0; ys < 4; ys++) begin
      b32.y_sel = 3'(ys); #1;
      chk($sformatf("rst_y%0d", ys), 64'(b32.alu_out), 64'd0);
    end
    b32.t_addr = 5'd9; #1;
    chk("rst_dout", 64'(b32.d_out), 64'd0);
    chk("rst_busy", 64'(b32.md_busy), 64'd0);
    chk("rst_done", 64'(b32.md_done), 64'd0);
    chk("rst_dz", 64'(b32.div_zero), 64'd0);

    // regfile
    b32.dy = 32'h1234; step();
    b32.y_sel = Y_DIN; b32.d_en = 1'b1;
    b32.da_sel = DA_D; b32.d_addr = 5'd5;
    step();
    b32.d_en = 1'b0; b32.t_addr = 5'd5; #1;
    chk("rf_r5", 64'(b32.d_out), 64'h1234);
    b32.dy = 32'hBEEF; step();
    b32.d_en = 1'b1; #1;
    chk("rf_old", 64'(b32.d_out), 64'h1234);
    step();
    b32.d_en = 1'b0; #1;
    chk("rf_new", 64'(b32.d_out), 64'hBEEF);
    b32.d_addr = 5'd0; b32.d_en = 1'b1; step();
    b32.d_en = 1'b0; b32.t_addr = 5'd0; #1;
    chk("rf_r0", 64'(b32.d_out), 64'd0);
    b32.da_sel = DA_LR; b32.d_en = 1'b1; step();
    b32.d_en = 1'b0; b32.t_addr = 5'd31; #1;
    chk("rf_lr", 64'(b32.d_out), 64'hBEEF);
    b32.y_sel = Y_PC; b32.pc_in = 32'hCAFE0000;
    b32.da_sel = DA_SP; b32.d_en = 1'b1; step();
    b32.d_en = 1'b0; b32.t_addr = 5'd29; #1;
    chk("rf_sp", 64'(b32.d_out), 64'hCAFE0000);
    b32.pc_in = 32'h77; b32.da_sel = DA_T;
    b32.t_addr = 5'd7; b32.d_en = 1'b1; step();
    b32.d_en = 1'b0; #1;
    chk("rf_dat", 64'(b32.d_out), 64'h77);
    b32.y_sel = 3'b101; #1;
    chk("ysel_5", 64'(b32.alu_out), 64'd0);

    // ALU directed
    alu_check("add_ovf", FS_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, got);
    chk("add_ovf_lit", 64'(got), {28'b0, 4'b0110, 32'h80000000});
    alu_check("subu_z", FS_SUBU, 32'd5, 32'd5, 5'd0, got);
    chk("subu_z_lit", 64'(got), {28'b0, 4'b1001, 32'h0});
    alu_check("sra", FS_SRA, 32'h0, 32'h80000010, 5'd4, got);
    alu_check("inc", FS_INC, 32'h7FFFFFFF, 32'h0, 5'd0, got);

    for (int i = 0; i < 24; i++) begin
      f = 4'($urandom_range(0, 15));
      alu_check($sformatf("alu%0d", i), f, pick(), pick(),
                5'($urandom_range(0, 31)), got);
    end

    // mul/div directed
    md_run("mult", MD_MULT, 32'hFFFFFFFD, 32'd7, 12);
    md_run("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 0);
    md_run("divz", MD_DIVU, 32'd100, 32'd0, 33);
    md_run("after_dz", MD_MULTU, 32'd6, 32'd9, 0);
    md_run("minneg1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    md_run("divz_s", MD_DIV, 32'hFFFFFF00, 32'd0, 0);

    for (int i = 0; i < 14; i++) begin
      op = 2'($urandom_range(0, 3));
      md_run($sformatf("md%0d", i), op, pick(), pick(),
             int'($urandom_range(0, 33)));
    end

    // reset in the middle of a run
    load32(32'd1000, 32'd3);
    b32.md_op = MD_DIVU; b32.md_start = 1'b1;
    step();
    b32.md_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b0; #1;
    exp_hi = '0; exp_lo = '0;
    chk("rstrun_busy", 64'(b32.md_busy), 64'd0);
    b32.y_sel = Y_HI; #1;
    chk("rstrun_hi", 64'(b32.alu_out), 64'd0);
    b32.y_sel = Y_LO; #1;
    chk("rstrun_lo", 64'(b32.alu_out), 64'd0);
    step();
    reset = 1'b1;
    step();
    md_run("post_rst", MD_DIVU, 32'd1000, 32'd3, 0);

    // 16-bit build
    md16("m16ff", MD_MULTU, 16'hFFFF, 16'hFFFF);
    md16("m16s", MD_MULT, 16'h8000, 16'h8000);
    md16("d16", MD_DIV, 16'hFFF9, 16'h0002);
    md16("d16z", MD_DIVU, 16'h0042, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom_range(0, 3));
      md16($sformatf("r16_%0d", i), op,
           16'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
